// File: rtl/loop_pattern_readout.sv
// Pattern bank (2**ADDR_WIDTH x PATTERN_WIDTH) dumped on request as a framed byte stream: header, count, data MSB-first, XOR checksum.
// Header is valid one cycle after the accepted request; each byte is held stable until i_tx_rdy, one byte per cycle with no stalls.
module loop_pattern_readout #(
    parameter int         ADDR_WIDTH    = 3,
    parameter int         PATTERN_WIDTH = 56,
    parameter logic [7:0] HEADER_BYTE   = 8'hA5
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_pattern_wr,
    input  logic [ADDR_WIDTH-1:0]    i_pattern_addr,
    input  logic [PATTERN_WIDTH-1:0] i_pattern,
    input  logic [ADDR_WIDTH-1:0]    i_pattern_num,
    input  logic                     i_read_req,
    output logic                     o_busy,
    output logic [7:0]               o_tx_data,
    output logic                     o_tx_valid,
    input  logic                     i_tx_rdy,
    output logic                     o_frame_done,
    output logic [2**ADDR_WIDTH-1:0] o_entry_written,
    output logic                     o_overrun
);
    localparam int DEPTH = 2**ADDR_WIDTH;
    localparam int BPE   = PATTERN_WIDTH / 8;
    localparam int BW    = (BPE > 1) ? $clog2(BPE) : 1;

    typedef enum logic [2:0] {IDLE, HEADER, COUNT, DATA, CHECK, DONE} state_t;

    state_t                   state, state_nx;
    logic [PATTERN_WIDTH-1:0] bank [DEPTH];
    logic [DEPTH-1:0]         written;
    logic [ADDR_WIDTH-1:0]    n_last, ent_idx, ent_step;
    logic [BW-1:0]            byte_idx, byte_step;
    logic [ADDR_WIDTH:0]      n_cnt;
    logic [7:0]               csum, tx_data, data_nx, cnt_byte;
    logic                     overrun, xfer, incomplete, last_byte, last_ent;

    // Byte idx of an entry, counted from the MSB end.
    function automatic logic [7:0] byte_of(input logic [PATTERN_WIDTH-1:0] entry,
                                           input logic [BW-1:0] idx);
        logic [PATTERN_WIDTH-1:0] sh;
        sh = entry << {idx, 3'b000};
        return sh[PATTERN_WIDTH-1 -: 8];
    endfunction

    assign o_tx_valid      = (state == HEADER) || (state == COUNT) || (state == DATA) || (state == CHECK);
    assign o_busy          = o_tx_valid;
    assign o_frame_done    = (state == DONE);
    assign o_tx_data       = tx_data;
    assign o_entry_written = written;
    assign o_overrun       = overrun;

    assign xfer      = o_tx_valid & i_tx_rdy;
    assign n_cnt     = {1'b0, n_last} + 1'b1;
    assign last_byte = (byte_idx == BW'(BPE - 1));
    assign last_ent  = (ent_idx == n_last);
    assign cnt_byte  = {incomplete, 3'b000, 4'(n_cnt)};

    always_comb begin
        incomplete = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if ((ADDR_WIDTH'(i) <= n_last) && !written[i]) incomplete = 1'b1;
        end
    end

    always_comb begin
        ent_step  = ent_idx;
        byte_step = byte_idx + 1'b1;
        if (last_byte) begin
            ent_step  = ent_idx + 1'b1;
            byte_step = '0;
        end
    end

    always_comb begin
        state_nx = state;
        data_nx  = tx_data;
        case (state)
            IDLE: if (i_read_req) begin
                state_nx = HEADER;
                data_nx  = HEADER_BYTE;
            end
            HEADER: if (xfer) begin
                state_nx = COUNT;
                data_nx  = cnt_byte;
            end
            COUNT: if (xfer) begin
                state_nx = DATA;
                data_nx  = byte_of(bank[0], '0);
            end
            DATA: if (xfer) begin
                if (last_byte && last_ent) begin
                    state_nx = CHECK;
                    data_nx  = csum ^ tx_data;
                end else begin
                    data_nx  = byte_of(bank[ent_step], byte_step);
                end
            end
            CHECK: if (xfer) begin
                state_nx = DONE;
                data_nx  = '0;
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state    <= IDLE;
            tx_data  <= '0;
            written  <= '0;
            overrun  <= 1'b0;
            n_last   <= '0;
            ent_idx  <= '0;
            byte_idx <= '0;
            csum     <= '0;
            for (int i = 0; i < DEPTH; i++) bank[i] <= '0;
        end else begin
            state   <= state_nx;
            tx_data <= data_nx;
            // Writes only land while idle so the bank is frozen for the whole frame.
            if (i_pattern_wr) begin
                if (state == IDLE) begin
                    bank[i_pattern_addr]    <= i_pattern;
                    written[i_pattern_addr] <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end
            if ((state == IDLE) && i_read_req) begin
                n_last   <= i_pattern_num;
                ent_idx  <= '0;
                byte_idx <= '0;
                csum     <= '0;
                overrun  <= 1'b0;
            end
            if (xfer && ((state == COUNT) || (state == DATA))) csum <= csum ^ tx_data;
            if (xfer && (state == DATA)) begin
                ent_idx  <= ent_step;
                byte_idx <= byte_step;
            end
        end
    end
endmodule
